// File: rtl/io_pkg.sv
// Shared constants and types for the switch/button input controller.
// Holds read offsets, status bit positions and the debounce state encoding.
package io_pkg;

  localparam logic [3:0] IO_OFF_STATUS = 4'h0;
  localparam logic [3:0] IO_OFF_DATA   = 4'h4;
  localparam logic [3:0] IO_OFF_LIVE   = 4'h8;

  localparam int ST_VALID = 0;
  localparam int ST_LEVEL = 1;
  localparam int ST_OVR   = 2;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

endpackage

// File: rtl/io_input_ctrl_if.sv
// CPU-side read bus of the input controller.
// The CPU is the master; the controller is the slave and also drives the interrupt line.
interface io_input_ctrl_if;

  logic        rd_en;
  logic [3:0]  rd_off;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;

  modport master (
    output rd_en,
    output rd_off,
    input  rd_data,
    input  rd_valid,
    input  irq
  );

  modport slave (
    input  rd_en,
    input  rd_off,
    output rd_data,
    output rd_valid,
    output irq
  );

endinterface

// File: rtl/io_input_ctrl_debounce.sv
// Push-button synchroniser and debounce FSM.
// Emits a single-cycle press_evt when a press has been stable long enough.
module btn_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press_evt,
  output logic btn_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_m;
  logic          btn_s;
  btn_state_t    state;
  btn_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= button;
      btn_s <= btn_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A bounce back to the held level during RELEASE_WAIT returns to PRESSED silently.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_evt = 1'b0;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = RELEASED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RELEASED;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign btn_level = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped input controller: synchronised switches, debounced button,
// one-entry mailbox captured on each press, and a registered read port.
module io_input_ctrl
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] switches,
  input  logic              button,
  io_input_ctrl_if.slave    bus
);

  logic [DATA_W-1:0] sw_m;
  logic [DATA_W-1:0] sw_s;
  logic [DATA_W-1:0] data_reg;
  logic              valid;
  logic              overrun;
  logic              press_evt;
  logic              btn_level;
  logic              data_rd;
  logic [31:0]       rd_data_nxt;
  logic [31:0]       status_word;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .press_evt(press_evt),
    .btn_level(btn_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= switches;
      sw_s <= sw_m;
    end
  end

  assign data_rd = bus.rd_en && (bus.rd_off == IO_OFF_DATA);

  // A press coinciding with a DATA read refills the mailbox; the old entry counts as consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else if (press_evt) begin
      data_reg <= sw_s;
      valid    <= 1'b1;
      overrun  <= valid && !data_rd;
    end else if (data_rd) begin
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end
  end

  always_comb begin
    status_word           = '0;
    status_word[ST_VALID] = valid;
    status_word[ST_LEVEL] = btn_level;
    status_word[ST_OVR]   = overrun;
  end

  always_comb begin
    rd_data_nxt = '0;
    if (bus.rd_en) begin
      case (bus.rd_off)
        IO_OFF_STATUS: rd_data_nxt = status_word;
        IO_OFF_DATA:   rd_data_nxt = 32'(data_reg);
        IO_OFF_LIVE:   rd_data_nxt = 32'(sw_s);
        default:       rd_data_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_data  <= rd_data_nxt;
      bus.rd_valid <= bus.rd_en;
    end
  end

  assign bus.irq = valid;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Scoreboard bench for io_input_ctrl: reads push expected words into a queue,
// a negedge monitor pops and compares whenever rd_valid is seen.
module tb_io_input_ctrl;
  import io_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] switches;
  logic       button;

  io_input_ctrl_if bus ();

  io_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DATA_W         (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .switches(switches),
    .button  (button),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one read; the response must appear right after the next edge.
  task automatic applyStimulus(input logic [3:0] off, input logic [31:0] exp, input string name);
    exp_t e;
    bus.rd_en  = 1'b1;
    bus.rd_off = off;
    e.val  = exp;
    e.cyc  = cyc + 1;
    e.name = name;
    sb.push_back(e);
    tick(1);
    bus.rd_en  = 1'b0;
    bus.rd_off = 4'h0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] exp);
    checks++;
    if (actual !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rd_valid: got rd_valid=1 data=%0h expected no response", bus.rd_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.rd_data !== e.val || cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL %s: got %0h at cycle %0d expected %0h at cycle %0d",
                   e.name, bus.rd_data, cyc, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    switches   = 8'h15;
    button     = 1'b0;
    bus.rd_en  = 1'b0;
    bus.rd_off = 4'h0;
    tick(2);
    rst = 1'b0;

    checkOutput("reset_irq", 32'(bus.irq), 32'h0);
    checkOutput("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    applyStimulus(IO_OFF_STATUS, 32'h0, "reset_status");
    applyStimulus(4'hC, 32'h0, "bad_offset");
    tick(2);

    // Clean press: event edge is six edges after the first sampling edge.
    button = 1'b1;
    tick(6);
    checkOutput("press_irq_early", 32'(bus.irq), 32'h0);
    tick(1);
    checkOutput("press_irq_on_time", 32'(bus.irq), 32'h1);
    tick(5);
    applyStimulus(IO_OFF_STATUS, 32'h3, "press_status");
    applyStimulus(IO_OFF_DATA, 32'h15, "press_data");
    checkOutput("press_irq_cleared", 32'(bus.irq), 32'h0);
    applyStimulus(IO_OFF_STATUS, 32'h2, "press_status_held");
    button = 1'b0;
    tick(10);

    // Short pulse must not be accepted.
    button = 1'b1;
    tick(3);
    button = 1'b0;
    tick(10);
    applyStimulus(IO_OFF_STATUS, 32'h0, "glitch_status");

    // Release bounce while pressed must not create a second event.
    button = 1'b1;
    tick(10);
    applyStimulus(IO_OFF_DATA, 32'h15, "bounce_first_data");
    button = 1'b0;
    tick(2);
    button = 1'b1;
    tick(10);
    applyStimulus(IO_OFF_STATUS, 32'h2, "bounce_status");
    button = 1'b0;
    tick(10);
    applyStimulus(IO_OFF_STATUS, 32'h0, "bounce_released");

    // Overrun: two presses without reading.
    button = 1'b1;
    tick(10);
    button = 1'b0;
    tick(10);
    switches = 8'h6D;
    tick(3);
    button = 1'b1;
    tick(10);
    button = 1'b0;
    tick(10);
    applyStimulus(IO_OFF_STATUS, 32'h5, "ovr_status");
    applyStimulus(IO_OFF_DATA, 32'h6D, "ovr_data");
    applyStimulus(IO_OFF_STATUS, 32'h0, "ovr_cleared");

    // Same-edge collision: DATA read lands on the press-event edge.
    switches = 8'h15;
    tick(3);
    button = 1'b1;
    tick(10);
    button = 1'b0;
    tick(10);
    switches = 8'h6D;
    tick(3);
    button = 1'b1;
    tick(6);
    applyStimulus(IO_OFF_DATA, 32'h15, "coll_old_data");
    applyStimulus(IO_OFF_STATUS, 32'h3, "coll_status");
    applyStimulus(IO_OFF_DATA, 32'h6D, "coll_new_data");
    button = 1'b0;
    tick(10);

    // Reset with valid set and button held.
    switches = 8'h15;
    tick(3);
    button = 1'b1;
    tick(10);
    checkOutput("prereset_irq", 32'(bus.irq), 32'h1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("postreset_irq", 32'(bus.irq), 32'h0);
    applyStimulus(IO_OFF_STATUS, 32'h0, "postreset_status");
    tick(5);
    checkOutput("rearm_irq_early", 32'(bus.irq), 32'h0);
    tick(1);
    checkOutput("rearm_irq_on_time", 32'(bus.irq), 32'h1);
    applyStimulus(IO_OFF_DATA, 32'h15, "rearm_data");

    // LIVE tracks switches through the two-flop synchroniser.
    switches = 8'h6D;
    applyStimulus(IO_OFF_LIVE, 32'h15, "live_0");
    applyStimulus(IO_OFF_LIVE, 32'h15, "live_1");
    applyStimulus(IO_OFF_LIVE, 32'h6D, "live_2");
    button = 1'b0;
    tick(4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_responses: got %0d outstanding expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
